// File: rtl/cam_frame_packer_if.sv
// cam_frame_packer_if: camera pixel stream in, packed DDR3 write-FIFO words out
interface cam_frame_packer_if #(parameter int OUT_W = 128);
  logic             cam_frame_vsync;
  logic             cam_frame_href;
  logic             cam_frame_valid;
  logic [15:0]      cam_frame_data;
  logic             fifo_full;
  logic             wr_en;
  logic [OUT_W-1:0] wr_data;
  modport master (output cam_frame_vsync, cam_frame_href, cam_frame_valid, cam_frame_data, fifo_full,
                  input wr_en, wr_data);
  modport slave (input cam_frame_vsync, cam_frame_href, cam_frame_valid, cam_frame_data, fifo_full,
                 output wr_en, wr_data);
endinterface

// File: rtl/cam_frame_packer.sv
// cam_frame_packer: checks frame geometry, packs RGB565 pixels into wide FIFO words, drops bad frames
module cam_frame_packer #(
  parameter int H_PIXEL = 1024,
  parameter int V_PIXEL = 768,
  parameter int OUT_W   = 128
) (
  input  logic                   cam_pclk,
  input  logic                   sys_rst,
  cam_frame_packer_if.slave      bus,
  output logic                   frame_start,
  output logic                   frame_done,
  output logic                   frame_err,
  output logic [7:0]             frame_cnt,
  output logic                   ovf_sticky
);
  localparam int PPW = OUT_W / 16;
  localparam int SW  = $clog2(PPW);
  localparam int HW  = $clog2(H_PIXEL + 1);
  localparam int VW  = $clog2(V_PIXEL + 1);
  localparam logic [HW-1:0] H_MAX  = HW'(H_PIXEL);
  localparam logic [VW-1:0] V_LAST = VW'(V_PIXEL - 1);
  localparam logic [SW-1:0] S_LAST = SW'(PPW - 1);
  typedef enum logic [1:0] {IDLE, ACTIVE, DROP, DONE} state_t;
  state_t st, st_n;
  logic vsync_d, href_d, wr_pend, done_r;
  logic vs_rise, h_fall, acc, line_ok, last_fall, ovf, take;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [SW-1:0] slot;
  logic [OUT_W-1:0] pack, word_n;
  always_comb begin
    vs_rise   = bus.cam_frame_vsync & ~vsync_d;
    h_fall    = href_d & ~bus.cam_frame_href;
    acc       = (st == ACTIVE) & ~vs_rise & bus.cam_frame_valid & bus.cam_frame_href;
    line_ok   = hcnt == H_MAX;
    take      = acc & ~line_ok;
    last_fall = (st == ACTIVE) & ~vs_rise & h_fall & line_ok & (vcnt == V_LAST);
    ovf       = wr_pend & bus.fifo_full;
    word_n    = pack;
    word_n[16*slot +: 16] = bus.cam_frame_data;
  end
  always_ff @(posedge cam_pclk or posedge sys_rst)
    if (sys_rst) st <= IDLE;
    else st <= st_n;
  // overflow, long line and short line all abandon the frame; a clean last line finishes it
  always_comb begin
    st_n = st;
    if (vs_rise) st_n = ACTIVE;
    else if (st == ACTIVE) begin
      if (ovf || (acc && line_ok) || (h_fall && !line_ok)) st_n = DROP;
      else if (last_fall) st_n = DONE;
    end
  end
  // the final word of a frame is still in flight at the last href fall, so done rides on its write
  always_comb begin
    bus.wr_en  = wr_pend & ~bus.fifo_full;
    frame_done = done_r | (last_fall & wr_pend & ~bus.fifo_full);
  end
  always_ff @(posedge cam_pclk or posedge sys_rst)
    if (sys_rst) begin
      vsync_d     <= 1'b0;
      href_d      <= 1'b0;
      frame_start <= 1'b0;
      frame_err   <= 1'b0;
      done_r      <= 1'b0;
      wr_pend     <= 1'b0;
      frame_cnt   <= '0;
      ovf_sticky  <= 1'b0;
      bus.wr_data <= '0;
      pack        <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
      slot        <= '0;
    end else begin
      vsync_d     <= bus.cam_frame_vsync;
      href_d      <= bus.cam_frame_href;
      frame_start <= vs_rise;
      frame_err   <= vs_rise & (st == ACTIVE || st == DROP);
      done_r      <= last_fall & ~wr_pend;
      wr_pend     <= take & (slot == S_LAST);
      frame_cnt   <= frame_cnt + {7'd0, frame_done};
      ovf_sticky  <= ovf_sticky | ovf;
      if (take && slot == S_LAST) bus.wr_data <= word_n;
      if (vs_rise || (st == ACTIVE && h_fall)) begin
        hcnt <= '0;
        slot <= '0;
      end else if (take) begin
        hcnt <= hcnt + 1'b1;
        slot <= (slot == S_LAST) ? '0 : slot + 1'b1;
        pack <= word_n;
      end
      if (vs_rise) vcnt <= '0;
      else if (st == ACTIVE && h_fall && line_ok) vcnt <= vcnt + 1'b1;
    end
endmodule

// File: tb/tb_cam_frame_packer.sv
// tb_cam_frame_packer: directed frames with hand-computed expectations for cam_frame_packer
module tb_cam_frame_packer;
  logic clk = 1'b0;
  logic rst;
  logic frame_start, frame_done, frame_err, ovf_sticky;
  logic [7:0] frame_cnt;
  int checks = 0, failures = 0;
  int n_wr, n_start, n_done, n_err, n_se, done_wr;
  logic [127:0] first_word, last_word;
  cam_frame_packer_if #(.OUT_W(128)) bus ();
  cam_frame_packer #(.H_PIXEL(16), .V_PIXEL(4), .OUT_W(128)) dut (
    .cam_pclk(clk), .sys_rst(rst), .bus(bus), .frame_start(frame_start), .frame_done(frame_done),
    .frame_err(frame_err), .frame_cnt(frame_cnt), .ovf_sticky(ovf_sticky));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.wr_en) begin
      if (n_wr == 0) first_word = bus.wr_data;
      last_word = bus.wr_data;
      n_wr++;
    end
    if (frame_start) n_start++;
    if (frame_err) n_err++;
    if (frame_start && frame_err) n_se++;
    if (frame_done) begin
      n_done++;
      if (bus.wr_en) done_wr++;
    end
  end
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    n_wr = 0; n_start = 0; n_done = 0; n_err = 0; n_se = 0; done_wr = 0;
    first_word = '0; last_word = '0;
  endtask
  task automatic line(input int base, input int n, input logic ff);
    bus.fifo_full = ff;
    bus.cam_frame_href = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.cam_frame_valid = 1'b1;
      bus.cam_frame_data = 16'(base + i);
      tick();
    end
    bus.cam_frame_valid = 1'b0;
    bus.cam_frame_href = 1'b0;
    tick();
    bus.fifo_full = 1'b0;
    tick();
  endtask
  task automatic vs();
    bus.cam_frame_vsync = 1'b1;
    tick();
    bus.cam_frame_vsync = 1'b0;
    tick();
  endtask
  task automatic frame(input int base);
    vs();
    for (int l = 0; l < 4; l++) line(base + 16 * l, 16, 1'b0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1;
    bus.cam_frame_vsync = 1'b0; bus.cam_frame_href = 1'b0; bus.cam_frame_valid = 1'b0;
    bus.cam_frame_data = '0; bus.fifo_full = 1'b0;
    clr();
    tick(); tick();
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_ovf", ovf_sticky, 0);
    rst = 1'b0;
    tick();
    frame(0);
    chk("f1_start", n_start, 1);
    chk("f1_nwr", n_wr, 8);
    chk("f1_first", first_word, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    chk("f1_last", last_word, 128'h003f_003e_003d_003c_003b_003a_0039_0038);
    chk("f1_done", n_done, 1);
    chk("f1_done_wr", done_wr, 1);
    chk("f1_cnt", frame_cnt, 1);
    chk("f1_err", n_err, 0);
    clr();
    vs();
    line(0, 16, 1'b0); line(16, 12, 1'b0); line(32, 16, 1'b0); line(48, 16, 1'b0);
    chk("short_nwr", n_wr, 3);
    chk("short_done", n_done, 0);
    chk("short_err_from_done", n_err, 0);
    clr();
    vs();
    chk("short_next_se", n_se, 1);
    line(0, 16, 1'b0); line(16, 16, 1'b1); line(32, 16, 1'b0); line(48, 16, 1'b0);
    chk("ovf_nwr", n_wr, 2);
    chk("ovf_sticky", ovf_sticky, 1);
    chk("ovf_done", n_done, 0);
    clr();
    frame(64);
    chk("ovf_next_se", n_se, 1);
    chk("ovf_next_nwr", n_wr, 8);
    chk("ovf_next_done", n_done, 1);
    chk("ovf_next_cnt", frame_cnt, 2);
    chk("ovf_still", ovf_sticky, 1);
    clr();
    vs();
    line(0, 16, 1'b0); line(16, 17, 1'b0); line(33, 16, 1'b0); line(49, 16, 1'b0);
    chk("long_nwr", n_wr, 4);
    chk("long_done", n_done, 0);
    clr();
    vs();
    chk("long_next_se", n_se, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("rst2_cnt", frame_cnt, 0);
    chk("rst2_ovf", ovf_sticky, 0);
    clr();
    line(0, 16, 1'b0); line(16, 16, 1'b0);
    chk("midframe_nwr", n_wr, 0);
    chk("midframe_start", n_start, 0);
    bus.cam_frame_vsync = 1'b1; bus.cam_frame_href = 1'b1; bus.cam_frame_valid = 1'b1;
    bus.cam_frame_data = 16'haaaa;
    tick();
    bus.cam_frame_vsync = 1'b0;
    line(16'h100, 16, 1'b0);
    for (int l = 1; l < 4; l++) line(16'h100 + 16 * l, 16, 1'b0);
    chk("coinc_first", first_word, 128'h0107_0106_0105_0104_0103_0102_0101_0100);
    chk("coinc_nwr", n_wr, 8);
    chk("coinc_err", n_err, 0);
    chk("coinc_cnt", frame_cnt, 1);
    vs();
    bus.cam_frame_href = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.cam_frame_valid = 1'b1;
      bus.cam_frame_data = 16'(i);
      tick();
    end
    chk("pre_rst_wr_en", bus.wr_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_wr_en", bus.wr_en, 0);
    chk("async_wr_data", bus.wr_data, 0);
    chk("async_cnt", frame_cnt, 0);
    chk("async_start", frame_start, 0);
    clr();
    tick();
    rst = 1'b0;
    line(8, 8, 1'b0); line(16, 16, 1'b0);
    chk("post_rst_nwr", n_wr, 0);
    chk("post_rst_start", n_start, 0);
    clr();
    for (int f = 0; f < 256; f++) begin
      frame(0);
      if (f == 254) chk("wrap_255", frame_cnt, 255);
    end
    chk("wrap_0", frame_cnt, 0);
    chk("wrap_done", n_done, 256);
    chk("wrap_err", n_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
